uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit arbiter.
//   state_e                 : arbiter FSM states
//   DEFAULT_TIMEOUT_CYCLES  : default watchdog limit, txStart -> txDone
//   CLOCK_RATE              : default system clock frequency in Hz
//   GRANT_W                 : width of grant indices (up to 8 requesters)
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // One 10-bit frame at 9600 baud on 12 MHz is 12500 cycles; leave margin.
  localparam int DEFAULT_TIMEOUT_CYCLES = 16384;
  localparam int CLOCK_RATE             = 12000000;
  localparam int GRANT_W                = 3;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- bundles the requester side, the Uart8 transmitter
// side and the status outputs of the arbiter.
//   slave  : arbiter view (requests/tx feedback in, handshake/tx/status out)
//   master : environment view (the reverse)
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic                   en;
  logic [NUM_REQ-1:0]     reqValid;
  logic [8*NUM_REQ-1:0]   reqData;
  logic [NUM_REQ-1:0]     reqReady;
  logic                   txEn;
  logic                   txStart;
  logic [7:0]             txData;
  logic                   txBusy;
  logic                   txDone;
  logic [2:0]             grantId;
  logic                   active;
  logic                   sentPulse;
  logic                   timeoutErr;

  modport slave (
    input  en, reqValid, reqData, txBusy, txDone,
    output reqReady, txEn, txStart, txData, grantId, active, sentPulse,
           timeoutErr
  );

  modport master (
    output en, reqValid, reqData, txBusy, txDone,
    input  reqReady, txEn, txStart, txData, grantId, active, sentPulse,
           timeoutErr
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   req        in  : request vector
//   last_grant in  : index granted most recently
//   found      out : at least one request is pending
//   index      out : first requester at or after last_grant+1, wrapping
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               found,
  output logic [GRANT_W-1:0] index
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a variable unassigned and no latch is inferred.
    found = 1'b0;
    index = '0;
    // Outer loop walks priority order (offset 1 is highest); the inner loop
    // keeps every vector index a constant.
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          found = 1'b1;
          index = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one Uart8 transmitter among NUM_REQ byte sources.
//   clk    in : system clock, rising edge
//   reset  in : synchronous, active-low reset
//   bus       : uart_tx_arbiter_if.slave
//               requester side : en, reqValid, reqData -> reqReady
//               Uart8 side     : txEn, txStart, txData <- txBusy, txDone
//               status         : grantId, active, sentPulse, timeoutErr
// A byte is accepted in IDLE, launched with a one-cycle txStart, and owned
// until txDone or until the watchdog gives up after TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int                 WD_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GRANT_W-1:0] LAST_RESET = GRANT_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
  logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 tx_en_q, tx_en_d;

  logic                 pick_found;
  logic [GRANT_W-1:0]   pick_idx;
  logic [7:0]           pick_data;
  logic                 grant_ok;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic                 sent_pulse;
  logic                 timeout_err;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (bus.reqValid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  // Winner's byte and one-hot ready, built with constant indices only.
  always_comb begin
    pick_data = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT_W'(i) == pick_idx) begin
        pick_data    = bus.reqData[8*i +: 8];
        req_ready[i] = grant_ok;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    grant_ok     = 1'b0;
    tx_start     = 1'b0;
    sent_pulse   = 1'b0;
    timeout_err  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gated by reset so no requester sees a handshake on an edge that
        // the reset discards.
        grant_ok = reset && bus.en && !bus.txBusy && pick_found;
        if (grant_ok) begin
          tx_data_d  = pick_data;
          grant_id_d = pick_idx;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        tx_start = 1'b1;
        wd_d     = '0;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // txDone takes precedence over a watchdog expiry in the same cycle.
        if (bus.txDone) begin
          sent_pulse   = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_err  = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The transmitter stays enabled while a byte is owned, whatever en does.
    tx_en_d = bus.en || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset) begin
      state_q      <= ST_IDLE;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RESET;
      wd_q         <= '0;
      tx_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      tx_en_q      <= tx_en_d;
    end
  end

  assign bus.reqReady   = req_ready;
  assign bus.txEn       = tx_en_q;
  assign bus.txStart    = tx_start;
  assign bus.txData     = tx_data_q;
  assign bus.grantId    = grant_id_q;
  assign bus.active     = (state_q != ST_IDLE);
  assign bus.sentPulse  = sent_pulse;
  assign bus.timeoutErr = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- directed bench for uart_tx_arbiter (NUM_REQ=4,
// TIMEOUT_CYCLES=64) with a small Uart8 stand-in that answers txStart with
// txBusy and a txDone pulse frame_len cycles later.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 64;

  logic clk;
  logic reset;
  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Uart8 stand-in.
  logic       model_on   = 1'b0;
  int         frame_len  = 4;
  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  logic [7:0] rx_byte    = 8'h00;
  assign bus.txBusy = model_busy | force_busy;

  initial begin : uart_model
    int cnt;
    logic [7:0] cap;
    cnt = 0;
    cap = 8'h00;
    bus.txDone = 1'b0;
    forever begin
      @(negedge clk);
      bus.txDone = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.txDone = 1'b1;
          model_busy = 1'b0;
          rx_byte    = cap;
        end
      end else if (model_on && bus.txStart) begin
        cap        = bus.txData;
        cnt        = frame_len;
        model_busy = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.reqValid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_start(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.txStart) seen = 1'b1;
    end
    check({name, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_sent(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.sentPulse) seen = 1'b1;
    end
    check({name, "_sent_seen"}, 32'(seen), 32'd1);
  endtask

  // IDLE grant decisions right after reset (lastGrant = 3).
  typedef struct {
    logic       en;
    logic       busy;
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [7:0]  gid [5];
    logic [7:0]  gdat[5];
    int unsigned gcyc[5];
    int          n;
    int          tmo_at;
    logic        s64, t64, txen_mid;

    vecs[0] = '{1'b1, 1'b0, 4'b0001, 4'b0001};
    vecs[1] = '{1'b1, 1'b0, 4'b1111, 4'b0001};
    vecs[2] = '{1'b1, 1'b0, 4'b1110, 4'b0010};
    vecs[3] = '{1'b1, 1'b0, 4'b1000, 4'b1000};
    vecs[4] = '{1'b1, 1'b0, 4'b1100, 4'b0100};
    vecs[5] = '{1'b0, 1'b0, 4'b1111, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 4'b1111, 4'b0000};
    vecs[7] = '{1'b1, 1'b0, 4'b0000, 4'b0000};

    reset        = 1'b0;
    bus.en       = 1'b1;
    bus.reqValid = 4'b1111;
    bus.reqData  = 32'hA3A2A1A0;

    // Reset state with requests pending.
    repeat (3) @(negedge clk);
    #1;
    check("rst_txStart",    32'(bus.txStart),    32'd0);
    check("rst_active",     32'(bus.active),     32'd0);
    check("rst_txEn",       32'(bus.txEn),       32'd0);
    check("rst_reqReady",   32'(bus.reqReady),   32'd0);
    check("rst_txData",     32'(bus.txData),     32'd0);
    check("rst_grantId",    32'(bus.grantId),    32'd0);
    check("rst_sentPulse",  32'(bus.sentPulse),  32'd0);
    check("rst_timeoutErr", 32'(bus.timeoutErr), 32'd0);
    bus.reqValid = '0;
    @(negedge clk);
    reset = 1'b1;

    // Table: ready is withdrawn before each edge, so no byte is accepted.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bus.en       = vecs[v].en;
      force_busy   = vecs[v].busy;
      bus.reqValid = vecs[v].valid;
      #1;
      check($sformatf("vec%0d_reqReady", v), 32'(bus.reqReady), 32'(vecs[v].ready));
      check($sformatf("vec%0d_active", v),   32'(bus.active),   32'd0);
      bus.reqValid = '0;
      force_busy   = 1'b0;
      bus.en       = 1'b1;
    end

    // Single request, requester drops valid and data right after acceptance.
    model_on  = 1'b1;
    frame_len = 5;
    @(negedge clk);
    bus.reqData  = 32'h44332235;
    bus.reqValid = 4'b0001;
    #1;
    check("single_reqReady", 32'(bus.reqReady), 32'h1);
    @(negedge clk);
    bus.reqValid = '0;
    bus.reqData  = 32'hFFFFFFFF;
    #1;
    check("single_txStart",  32'(bus.txStart),  32'd1);
    check("single_txData",   32'(bus.txData),   32'h35);
    check("single_grantId",  32'(bus.grantId),  32'd0);
    check("single_active",   32'(bus.active),   32'd1);
    check("single_ready_lo", 32'(bus.reqReady), 32'h0);
    @(negedge clk);
    #1;
    check("single_start_once", 32'(bus.txStart), 32'd0);
    check("single_txData_hold", 32'(bus.txData), 32'h35);
    wait_sent(20, "single");
    check("single_timeoutErr", 32'(bus.timeoutErr), 32'd0);
    check("single_rx_byte",    32'(rx_byte),        32'h35);

    // Fairness with back-to-back frames: order 0,1,2,3,0, spacing 3.
    do_reset();
    frame_len    = 1;
    bus.reqData  = 32'hA3A2A1A0;
    bus.reqValid = 4'b1111;
    n = 0;
    for (int i = 0; i < 60 && n < 5; i++) begin
      @(negedge clk);
      #1;
      if (bus.txStart) begin
        gid[n]  = 8'(bus.grantId);
        gdat[n] = bus.txData;
        gcyc[n] = cyc;
        n++;
      end
    end
    bus.reqValid = '0;
    check("fair_count", 32'(n), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fair_grant%0d", k), 32'(gid[k]),  32'(k % 4));
      check($sformatf("fair_data%0d", k),  32'(gdat[k]), 32'(8'hA0 + 8'(k % 4)));
    end
    for (int k = 1; k < 5; k++)
      check($sformatf("fair_spacing%0d", k), gcyc[k] - gcyc[k-1], 32'd3);
    wait_sent(10, "fair");

    // Wrap priority: lastGrant=2, requests {0,2} -> 0 wins.
    do_reset();
    frame_len = 2;
    @(negedge clk);
    bus.reqValid = 4'b0100;
    wait_start(10, "wrap_pre");
    check("wrap_pre_grant", 32'(bus.grantId), 32'd2);
    bus.reqValid = '0;
    wait_sent(10, "wrap_pre");
    @(negedge clk);
    bus.reqValid = 4'b0101;
    #1;
    check("wrap_reqReady", 32'(bus.reqReady), 32'h1);
    wait_start(10, "wrap");
    check("wrap_grant", 32'(bus.grantId), 32'd0);
    bus.reqValid = '0;
    wait_sent(10, "wrap");

    // Timeout: no txDone, expiry exactly TMO cycles after txStart.
    model_on = 1'b0;
    @(negedge clk);
    bus.reqValid = 4'b1111;
    wait_start(10, "tmo");
    check("tmo_grant", 32'(bus.grantId), 32'd1);
    tmo_at = -1;
    for (int c = 1; c <= 100 && tmo_at < 0; c++) begin
      @(negedge clk);
      #1;
      if (bus.timeoutErr) begin
        tmo_at = c;
        check("tmo_sentPulse", 32'(bus.sentPulse), 32'd0);
      end
    end
    check("tmo_latency", 32'(tmo_at), 32'(TMO));
    model_on  = 1'b1;
    frame_len = 3;
    wait_start(10, "tmo_next");
    check("tmo_next_grant", 32'(bus.grantId), 32'd2);
    bus.reqValid = '0;
    wait_sent(10, "tmo_next");

    // Collision of txDone and expiry; en drops mid-frame without aborting.
    frame_len = TMO;
    @(negedge clk);
    bus.reqValid = 4'b0001;
    wait_start(10, "coll");
    check("coll_grant", 32'(bus.grantId), 32'd0);
    bus.reqValid = '0;
    s64 = 1'b0;
    t64 = 1'b0;
    txen_mid = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      if (c == 2) bus.en = 1'b0;
      #1;
      if (c == 10) txen_mid = bus.txEn;
      if (c == TMO) begin
        s64 = bus.sentPulse;
        t64 = bus.timeoutErr;
      end
    end
    check("coll_txEn_held",   32'(txen_mid), 32'd1);
    check("coll_sentPulse",   32'(s64),      32'd1);
    check("coll_timeoutErr",  32'(t64),      32'd0);
    @(negedge clk);
    bus.reqValid = 4'b0001;
    #1;
    check("en_lo_reqReady", 32'(bus.reqReady), 32'h0);
    check("en_lo_active",   32'(bus.active),   32'd0);
    @(negedge clk);
    #1;
    check("en_lo_txEn", 32'(bus.txEn), 32'd0);
    bus.reqValid = '0;
    bus.en       = 1'b1;

    // Reset mid-frame, then requester 0 gets first priority.
    model_on = 1'b0;
    @(negedge clk);
    bus.reqValid = 4'b0100;
    wait_start(10, "rstmid");
    check("rstmid_grant", 32'(bus.grantId), 32'd2);
    bus.reqValid = '0;
    repeat (3) @(negedge clk);
    reset        = 1'b0;
    bus.reqValid = 4'b0101;
    @(negedge clk);
    #1;
    check("rstmid_active",     32'(bus.active),     32'd0);
    check("rstmid_txStart",    32'(bus.txStart),    32'd0);
    check("rstmid_txData",     32'(bus.txData),     32'd0);
    check("rstmid_grantId",    32'(bus.grantId),    32'd0);
    check("rstmid_txEn",       32'(bus.txEn),       32'd0);
    check("rstmid_sentPulse",  32'(bus.sentPulse),  32'd0);
    check("rstmid_timeoutErr", 32'(bus.timeoutErr), 32'd0);
    check("rstmid_reqReady",   32'(bus.reqReady),   32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid_first_ready", 32'(bus.reqReady), 32'h1);
    wait_start(10, "rstmid_after");
    check("rstmid_after_grant", 32'(bus.grantId), 32'd0);
    bus.reqValid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
